alu_muldiv_iter: RTL and testbench
==================================

Name: alu_muldiv_iter

Overview:
- Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage beside the combinational ALU and takes over the HI/LO path (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
- Uses a start/busy/done handshake so the pipeline stalls while it iterates.
- Supports flush cancel on exception.

Parameters:
- WIDTH, 32: operand width and width of each of HI and LO. Must be even and ≥ 8.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (ignored, no done).
- src_a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- src_b  in  WIDTH  multiplier / divisor.
- cancel  in  1  flush; aborts any operation in flight.
- busy  out  1  high while an iterative op is in flight.
- done  out  1  one-cycle pulse; HI/LO already hold the result in this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clock port "clock", reset port "reset").
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset during CALC/FIX discards the operation; no done is produced.
- FSM states IDLE, CALC, FIX.
- IDLE, start=1, cancel=0, op∈{0..3}:
  - latch op; latch |src_a|, |src_b| (signed ops) or raw values (unsigned ops);
  - latch result sign(s); counter←0; go to CALC; busy=1 from the next cycle.
- IDLE, start=1, op∈{4,5}:
  - hi (MTHI) or lo (MTLO) ← src_a at that edge;
  - done=1 in the next cycle; busy stays 0; the other register is untouched.
- CALC: one radix-2 step per cycle for WIDTH cycles; counter increments; on counter=WIDTH-1 go to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX: one cycle.
  - Apply sign correction.
  - Multiply: negate the 2*WIDTH product if the operand signs differ.
  - Divide: quotient negative if the signs differ; remainder takes the dividend's sign.
  - Write hi/lo at the FIX→IDLE edge: mult hi=product[2W-1:W], lo=product[W-1:0]; div lo=quotient, hi=remainder.
  - busy←0, done←1 on the same edge.
- Latency: start accepted at edge E0; done=1 in the cycle after edge E(WIDTH+1). For WIDTH=32: 33 cycles. busy is high for exactly WIDTH+1 cycles.
- Divide by zero (src_b=0): no exception; lo=all ones, hi=src_a (unsigned view), for both DIV and DIVU. Same latency.
- Signed overflow DIV MIN/-1: lo=MIN (e.g. 0x80000000), hi=0.
- start while busy=1: ignored, with no effect on the in-flight op.
- cancel=1 in any state:
  - next state IDLE, busy=0, done=0, hi/lo unchanged (a FIX-cycle cancel also blocks the write).
  - cancel and start in the same cycle: cancel wins, start dropped (including MTHI/MTLO).
- done never asserts for two consecutive cycles except for back-to-back MTHI/MTLO.
- Operand inputs need not be held after acceptance.

Test Plan:
- Signed multiply: reset, then MULT src_a=0xFFFFFFFE, src_b=0x00000003 -> busy high 33 cycles; done pulse 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned multiply: MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA; same latency.
- Signed divide: DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU src_a=100, src_b=0 -> lo=0xFFFFFFFF, hi=0x00000064; no hang.
- Cancel mid-operation: MTHI 0x12345678 (hi updates next edge, done pulses once, busy never high), then MULT 5*7 with cancel at CALC cycle 10 -> busy=0 next cycle; no done; hi=0x12345678 retained.
- Start collision: a second start (MTLO 0xAA) during the busy MULT 5*7 is ignored -> lo=0x23, hi=0.
- Reset/cancel priority: reset asserted during FIX -> hi=lo=0, done never asserts. Simultaneous start+cancel in IDLE -> no state change.

Source files
------------

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply/divide unit that owns the architectural HI/LO registers.
// A start/busy/done handshake lets the pipeline stall while it iterates; cancel aborts it.
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t               state_q, state_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_q, neg_d;
   logic                 rem_neg_q, rem_neg_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;

   logic                 op_signed, op_is_div, sign_a, sign_b, div_zero;
   logic [WIDTH-1:0]     abs_a, abs_b;

   always_comb begin
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      op_is_div = (op == OP_DIV) || (op == OP_DIVU);
      sign_a    = op_signed & src_a[WIDTH-1];
      sign_b    = op_signed & src_b[WIDTH-1];
      abs_a     = sign_a ? -src_a : src_a;
      abs_b     = sign_b ? -src_b : src_b;
      div_zero  = op_is_div && (src_b == '0);
   end

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   logic [WIDTH:0]       mul_sum, div_trial;
   logic [WIDTH-1:0]     div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   step_acc;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_trial = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge    = div_trial >= {1'b0, b_q};
      div_diff  = div_trial[WIDTH-1:0] - b_q;
      if (is_div_q)
         step_acc = {(div_ge ? div_diff : div_trial[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
      else
         step_acc = {mul_sum, acc_q[WIDTH-1:1]};
   end

   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quot_fix, rem_fix;

   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d   = state_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      if (cancel) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        is_div_d = op_is_div;
                        cnt_d    = '0;
                        state_d  = S_CALC;
                        // Raw dividend with a zero divisor makes the loop yield q=all ones, r=src_a
                        if (div_zero) begin
                           acc_d     = {{WIDTH{1'b0}}, src_a};
                           b_d       = '0;
                           neg_d     = 1'b0;
                           rem_neg_d = 1'b0;
                        end else begin
                           acc_d     = {{WIDTH{1'b0}}, abs_a};
                           b_d       = abs_b;
                           neg_d     = sign_a ^ sign_b;
                           rem_neg_d = sign_a;
                        end
                     end
                     OP_MTHI: begin
                        hi_d   = src_a;
                        done_d = 1'b1;
                     end
                     OP_MTLO: begin
                        lo_d   = src_a;
                        done_d = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            S_CALC: begin
               acc_d = step_acc;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1))
                  state_d = S_FIX;
            end
            S_FIX: begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               if (is_div_q) begin
                  lo_d = quot_fix;
                  hi_d = rem_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Scoreboard bench for alu_muldiv_iter: a reference model pushes expected HI/LO when an op
// is issued, and each scenario task pops and compares when the unit reports done.
module tb_alu_muldiv_iter;
   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  src_a;
   logic [W-1:0]  src_b;
   logic          cancel;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } res_t;

   res_t         exp_q[$];
   logic [W-1:0] model_hi = '0;
   logic [W-1:0] model_lo = '0;

   always #5 clock = ~clock;

   alu_muldiv_iter #(.WIDTH(W)) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic void model_push(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t        r;
      longint      sp;
      logic [63:0] up;
      r.hi = model_hi;
      r.lo = model_lo;
      case (o)
         3'd0: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {r.hi, r.lo} = sp;
         end
         3'd1: begin
            up = {32'd0, a} * {32'd0, b};
            {r.hi, r.lo} = up;
         end
         3'd2: begin
            if (b == 0) begin
               r.lo = '1;
               r.hi = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               r.lo = 32'h8000_0000;
               r.hi = '0;
            end else begin
               r.lo = $signed(a) / $signed(b);
               r.hi = $signed(a) % $signed(b);
            end
         end
         3'd3: begin
            if (b == 0) begin
               r.lo = '1;
               r.hi = a;
            end else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
         3'd4: r.hi = a;
         3'd5: r.lo = a;
         default: return;
      endcase
      model_hi = r.hi;
      model_lo = r.lo;
      exp_q.push_back(r);
   endfunction

   // Drives one start cycle; operands are scrambled right after acceptance.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_res);
      op    = o;
      src_a = a;
      src_b = b;
      start = 1'b1;
      if (expect_res)
         model_push(o, a, b);
      $display("issue op=%0d a=%h b=%h expect_result=%0d", o, a, b, expect_res);
      tick();
      start = 1'b0;
      src_a = $urandom();
      src_b = $urandom();
   endtask

   task automatic wait_done(output int lat, output int busy_cyc, output bit got);
      lat      = 0;
      busy_cyc = 0;
      while (done !== 1'b1 && lat < 200) begin
         if (busy === 1'b1)
            busy_cyc++;
         tick();
         lat++;
      end
      got = (done === 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src_a = '0; src_b = '0;
      repeat (3) tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (hi !== '0) begin failures++; $display("FAIL reset_hi: got %h expected 0", hi); end
      checks++; if (lo !== '0) begin failures++; $display("FAIL reset_lo: got %h expected 0", lo); end
      reset = 1'b0;
      tick();
   endtask

   // Shared body shape for the iterative arithmetic scenarios.
   task automatic test_mult();
      logic [2:0]   ops[2] = '{3'd0, 3'd1};
      int lat, bc; bit got; res_t e;
      for (int i = 0; i < 2; i++) begin
         issue(ops[i], 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
         wait_done(lat, bc, got);
         e = exp_q.pop_front();
         checks++; if (!got || lat != LAT) begin failures++; $display("FAIL mult_latency op=%0d: got %0d expected %0d", ops[i], lat, LAT); end
         checks++; if (bc != LAT) begin failures++; $display("FAIL mult_busy_cycles op=%0d: got %0d expected %0d", ops[i], bc, LAT); end
         checks++; if (hi !== e.hi) begin failures++; $display("FAIL mult_hi op=%0d: got %h expected %h", ops[i], hi, e.hi); end
         checks++; if (lo !== e.lo) begin failures++; $display("FAIL mult_lo op=%0d: got %h expected %h", ops[i], lo, e.lo); end
         tick();
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse op=%0d: got %b expected 0", ops[i], done); end
      end
   endtask

   task automatic test_div();
      logic [W-1:0] as[2] = '{32'hFFFF_FFF9, 32'h8000_0000};
      logic [W-1:0] bs[2] = '{32'h0000_0002, 32'hFFFF_FFFF};
      int lat, bc; bit got; res_t e;
      for (int i = 0; i < 2; i++) begin
         issue(3'd2, as[i], bs[i], 1'b1);
         wait_done(lat, bc, got);
         e = exp_q.pop_front();
         checks++; if (!got || lat != LAT) begin failures++; $display("FAIL div_latency #%0d: got %0d expected %0d", i, lat, LAT); end
         checks++; if (hi !== e.hi) begin failures++; $display("FAIL div_hi #%0d: got %h expected %h", i, hi, e.hi); end
         checks++; if (lo !== e.lo) begin failures++; $display("FAIL div_lo #%0d: got %h expected %h", i, lo, e.lo); end
      end
   endtask

   task automatic test_div_zero();
      logic [2:0]   ops[2] = '{3'd3, 3'd2};
      logic [W-1:0] as[2]  = '{32'd100, 32'hFFFF_FFF0};
      int lat, bc; bit got; res_t e;
      for (int i = 0; i < 2; i++) begin
         issue(ops[i], as[i], '0, 1'b1);
         wait_done(lat, bc, got);
         e = exp_q.pop_front();
         checks++; if (!got || lat != LAT) begin failures++; $display("FAIL divzero_latency op=%0d: got %0d expected %0d", ops[i], lat, LAT); end
         checks++; if (hi !== e.hi) begin failures++; $display("FAIL divzero_hi op=%0d: got %h expected %h", ops[i], hi, e.hi); end
         checks++; if (lo !== e.lo) begin failures++; $display("FAIL divzero_lo op=%0d: got %h expected %h", ops[i], lo, e.lo); end
      end
   endtask

   task automatic test_mthi_cancel();
      res_t e; bit seen_done = 0; bit seen_busy = 0;
      issue(3'd4, 32'h1234_5678, '0, 1'b1);
      e = exp_q.pop_front();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL mthi_done: got %b expected 1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy: got %b expected 0", busy); end
      checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL mthi_regs: got %h/%h expected %h/%h", hi, lo, e.hi, e.lo); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mthi_done_pulse: got %b expected 0", done); end
      issue(3'd0, 32'd5, 32'd7, 1'b0);
      repeat (10) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy: got %b expected 0", busy); end
      for (int i = 0; i < 50; i++) begin
         if (done === 1'b1) seen_done = 1;
         if (busy === 1'b1) seen_busy = 1;
         tick();
      end
      checks++; if (seen_done || seen_busy) begin failures++; $display("FAIL cancel_quiet: got done=%0d busy=%0d expected 0/0", seen_done, seen_busy); end
      checks++; if (hi !== model_hi || lo !== model_lo) begin failures++; $display("FAIL cancel_regs: got %h/%h expected %h/%h", hi, lo, model_hi, model_lo); end
   endtask

   task automatic test_start_collision();
      int lat, bc; bit got; res_t e; bit seen_done = 0;
      issue(3'd0, 32'd5, 32'd7, 1'b1);
      repeat (5) tick();
      op = 3'd5; src_a = 32'h0000_00AA; start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      wait_done(lat, bc, got);
      e = exp_q.pop_front();
      checks++; if (!got || lat + 8 != LAT) begin failures++; $display("FAIL collision_latency: got %0d expected %0d", lat + 8, LAT); end
      checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL collision_regs: got %h/%h expected %h/%h", hi, lo, e.hi, e.lo); end
      tick();
      for (int i = 0; i < 10; i++) begin
         if (done === 1'b1) seen_done = 1;
         tick();
      end
      checks++; if (seen_done || lo !== model_lo) begin failures++; $display("FAIL collision_after: got done=%0d lo=%h expected 0 %h", seen_done, lo, model_lo); end
   endtask

   task automatic test_reset_fix();
      res_t e; bit seen_done = 0;
      issue(3'd4, 32'hCAFE_F00D, '0, 1'b1);
      e = exp_q.pop_front();
      checks++; if (hi !== e.hi) begin failures++; $display("FAIL resetfix_setup_hi: got %h expected %h", hi, e.hi); end
      tick();
      issue(3'd3, 32'd1000, 32'd7, 1'b0);
      repeat (W) tick();
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL resetfix_in_fix: got busy=%b done=%b expected 1/0", busy, done); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_hi = '0;
      model_lo = '0;
      checks++; if (hi !== model_hi || lo !== model_lo) begin failures++; $display("FAIL resetfix_regs: got %h/%h expected 0/0", hi, lo); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL resetfix_ctrl: got busy=%b done=%b expected 0/0", busy, done); end
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) seen_done = 1;
         tick();
      end
      checks++; if (seen_done) begin failures++; $display("FAIL resetfix_no_done: got done pulse expected none"); end
   endtask

   task automatic test_start_cancel_idle();
      op = 3'd4; src_a = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
      tick();
      checks++; if (done !== 1'b0 || hi !== model_hi) begin failures++; $display("FAIL startcancel_mthi: got done=%b hi=%h expected 0 %h", done, hi, model_hi); end
      op = 3'd0; src_a = 32'd9; src_b = 32'd9;
      tick();
      start = 1'b0; cancel = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL startcancel_mult: got busy=%b done=%b expected 0/0", busy, done); end
      tick();
      checks++; if (busy !== 1'b0 || lo !== model_lo) begin failures++; $display("FAIL startcancel_after: got busy=%b lo=%h expected 0 %h", busy, lo, model_lo); end
   endtask

   task automatic test_back_to_back();
      res_t e; int lat, bc; bit got;
      logic [2:0] o; logic [W-1:0] a, b;
      op = 3'd4; src_a = 32'h1111_2222; start = 1'b1;
      model_push(3'd4, 32'h1111_2222, '0);
      tick();
      e = exp_q.pop_front();
      checks++; if (done !== 1'b1 || hi !== e.hi) begin failures++; $display("FAIL b2b_mthi: got done=%b hi=%h expected 1 %h", done, hi, e.hi); end
      op = 3'd5; src_a = 32'h3333_4444;
      model_push(3'd5, 32'h3333_4444, '0);
      tick();
      start = 1'b0;
      e = exp_q.pop_front();
      checks++; if (done !== 1'b1 || lo !== e.lo || hi !== e.hi) begin failures++; $display("FAIL b2b_mtlo: got done=%b %h/%h expected 1 %h/%h", done, hi, lo, e.hi, e.lo); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
      for (int i = 0; i < 16; i++) begin
         o = 3'($urandom_range(0, 5));
         a = $urandom();
         b = ($urandom_range(0, 4) == 0) ? '0 : $urandom();
         if (i == 3) begin a = 32'h8000_0000; b = 32'h8000_0000; o = 3'd0; end
         issue(o, a, b, 1'b1);
         wait_done(lat, bc, got);
         e = exp_q.pop_front();
         checks++; if (!got || hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL rand_op%0d op=%0d a=%h b=%h: got %h/%h done=%0d expected %h/%h", i, o, a, b, hi, lo, got, e.hi, e.lo); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_mthi_cancel();
      test_start_collision();
      test_reset_fix();
      test_start_cancel_idle();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
